// File: rtl/pipelined_carry_select_adder_pkg.sv
// Shared types, defaults and helpers for the pipelined carry-select adder.
// Optional feature macro: CSA_PIPE_OVF_EN (adds the signed-overflow output).
package csa_pkg;

   localparam int CSA_DEF_WIDTH   = 32;
   localparam int CSA_DEF_BLOCK_W = 8;
   // Widest block the struct can carry; blocks use the low BLOCK_W bits.
   localparam int CSA_MAX_BLOCK_W = 128;

   // Speculative results of one block for carry-in 0 (s0/c0) and 1 (s1/c1).
   typedef struct packed {
      logic [CSA_MAX_BLOCK_W-1:0] s0;
      logic [CSA_MAX_BLOCK_W-1:0] s1;
      logic                       c0;
      logic                       c1;
   } csa_blk_t;

   function automatic int csa_nblk(input int width, input int block_w);
      return width / block_w;
   endfunction

endpackage

// File: rtl/pipelined_carry_select_adder_block.sv
// One carry-select block: both speculative sums and carries, purely combinational.
// Optional feature macro: CSA_PIPE_OVF_EN (not used in this file).
module csa_block
   import csa_pkg::*;
#(
   parameter int BLOCK_W = CSA_DEF_BLOCK_W
) (
   input  logic [BLOCK_W-1:0] a_i,
   input  logic [BLOCK_W-1:0] b_i,
   output csa_blk_t           blk_o
);

   logic [BLOCK_W:0] sum0;
   logic [BLOCK_W:0] sum1;

   // Compute the block sum for both possible carry-ins and pack them.
   always_comb begin
      sum0  = {1'b0, a_i} + {1'b0, b_i};
      sum1  = {1'b0, a_i} + {1'b0, b_i} + {{BLOCK_W{1'b0}}, 1'b1};
      blk_o = '0;
      blk_o.s0[BLOCK_W-1:0] = sum0[BLOCK_W-1:0];
      blk_o.s1[BLOCK_W-1:0] = sum1[BLOCK_W-1:0];
      blk_o.c0              = sum0[BLOCK_W];
      blk_o.c1              = sum1[BLOCK_W];
   end

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Two-stage carry-select adder/subtractor with valid/ready handshakes.
// Stage 1 captures block 0 with the real carry-in plus speculative pairs for
// the upper blocks; stage 2 ripples the block carries through muxes.
// Optional feature macro: CSA_PIPE_OVF_EN adds port ovf and its pipeline bits.
module pipelined_carry_select_adder
   import csa_pkg::*;
#(
   parameter int WIDTH   = CSA_DEF_WIDTH,
   parameter int BLOCK_W = CSA_DEF_BLOCK_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
`ifdef CSA_PIPE_OVF_EN
   output logic             ovf,
`endif
   output logic             Cout
);

   localparam int NBLK = csa_nblk(WIDTH, BLOCK_W);
   // Upper-block storage count; kept at least 1 so NBLK==1 stays legal.
   localparam int NHI  = (NBLK > 1) ? NBLK - 1 : 1;

   if ((WIDTH % BLOCK_W) != 0 || WIDTH < 8 || WIDTH > 128 || BLOCK_W > CSA_MAX_BLOCK_W)
   begin : g_bad_cfg
      $error("pipelined_carry_select_adder: illegal WIDTH/BLOCK_W combination");
   end

   // ---------------- stage 1 inputs ----------------
   logic [WIDTH-1:0]   b_eff;
   logic               cin_eff;
   logic [BLOCK_W:0]   blk0_sum;
   csa_blk_t           hi_blk [NHI];

   assign b_eff    = sub ? ~B : B;
   assign cin_eff  = sub | Cin;
   assign blk0_sum = {1'b0, A[BLOCK_W-1:0]} + {1'b0, b_eff[BLOCK_W-1:0]}
                   + {{BLOCK_W{1'b0}}, cin_eff};

   for (genvar k = 1; k < NBLK; k++) begin : g_blk
      csa_block #(.BLOCK_W(BLOCK_W)) u_blk (
         .a_i   (A[k*BLOCK_W +: BLOCK_W]),
         .b_i   (b_eff[k*BLOCK_W +: BLOCK_W]),
         .blk_o (hi_blk[k-1])
      );
   end
   if (NBLK == 1) begin : g_no_hi
      assign hi_blk[0] = '0;
   end

   // ---------------- pipeline state ----------------
   logic               s1_valid_q, s1_valid_d;
   logic [BLOCK_W-1:0] s1_sum0_q;
   logic               s1_c0_q;
   csa_blk_t           s1_hi_q [NHI];
   logic               s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic               cout_q, cout_d;
   logic               s1_adv, s2_adv, s1_load, s2_load;
`ifdef CSA_PIPE_OVF_EN
   logic               s1_amsb_q, s1_bmsb_q;
   logic               ovf_q, ovf_d;
`endif

   // Handshake control: a stage moves when empty or when its consumer moves.
   always_comb begin
      s2_adv     = !s2_valid_q || out_ready;
      s1_adv     = !s1_valid_q || s2_adv;
      s1_load    = in_valid && s1_adv;
      s2_load    = s1_valid_q && s2_adv;
      s1_valid_d = s1_adv ? in_valid : s1_valid_q;
      s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
   end

   assign in_ready = s1_adv;

   // Stage 2 carry resolution: select each upper block by the running carry.
   always_comb begin
      logic carry;
      carry = s1_c0_q;
      s_d   = '0;
      s_d[BLOCK_W-1:0] = s1_sum0_q;
      for (int k = 1; k < NBLK; k++) begin
         s_d[k*BLOCK_W +: BLOCK_W] = carry ? s1_hi_q[k-1].s1[BLOCK_W-1:0]
                                           : s1_hi_q[k-1].s0[BLOCK_W-1:0];
         carry = carry ? s1_hi_q[k-1].c1 : s1_hi_q[k-1].c0;
      end
      cout_d = carry;
`ifdef CSA_PIPE_OVF_EN
      ovf_d = (s1_amsb_q == s1_bmsb_q) && (s_d[WIDTH-1] != s1_amsb_q);
`endif
   end

   // Stage 1 register: block-0 result and speculative upper-block pairs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sum0_q  <= '0;
         s1_c0_q    <= 1'b0;
         for (int k = 0; k < NHI; k++) s1_hi_q[k] <= '0;
`ifdef CSA_PIPE_OVF_EN
         s1_amsb_q  <= 1'b0;
         s1_bmsb_q  <= 1'b0;
`endif
      end else begin
         s1_valid_q <= s1_valid_d;
         if (s1_load) begin
            s1_sum0_q <= blk0_sum[BLOCK_W-1:0];
            s1_c0_q   <= blk0_sum[BLOCK_W];
            for (int k = 0; k < NHI; k++) s1_hi_q[k] <= hi_blk[k];
`ifdef CSA_PIPE_OVF_EN
            s1_amsb_q <= A[WIDTH-1];
            s1_bmsb_q <= b_eff[WIDTH-1];
`endif
         end
      end
   end

   // Stage 2 register: resolved sum, carry-out (and overflow); holds on stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s_q        <= '0;
         cout_q     <= 1'b0;
`ifdef CSA_PIPE_OVF_EN
         ovf_q      <= 1'b0;
`endif
      end else begin
         s2_valid_q <= s2_valid_d;
         if (s2_load) begin
            s_q    <= s_d;
            cout_q <= cout_d;
`ifdef CSA_PIPE_OVF_EN
            ovf_q  <= ovf_d;
`endif
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign S         = s_q;
   assign Cout      = cout_q;
`ifdef CSA_PIPE_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Directed + short random bench for pipelined_carry_select_adder (32/8 build).
// Honours CSA_PIPE_OVF_EN: the overflow bit is compared only when it exists.
module tb_pipelined_carry_select_adder;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
   logic [W-1:0] a, b, s;
`ifdef CSA_PIPE_OVF_EN
   logic         ovf;
`endif

   int           n_chk = 0;
   int           n_err = 0;
   int           stall_cnt = 0;
   logic [33:0]  exp_q[$];

   always #5 clk = ~clk;

   pipelined_carry_select_adder #(.WIDTH(W), .BLOCK_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a),
      .B         (b),
      .Cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (s),
`ifdef CSA_PIPE_OVF_EN
      .ovf       (ovf),
`endif
      .Cout      (cout)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {ovf, Cout, S}; ovf forced to 0 when the feature is not built.
   function automatic logic [33:0] pk(input logic [31:0] es, input logic ec, input logic ev);
`ifdef CSA_PIPE_OVF_EN
      return {ev, ec, es};
`else
      return {1'b0 & ev, ec, es};
`endif
   endfunction

   function automatic logic [33:0] obs();
`ifdef CSA_PIPE_OVF_EN
      return {ovf, cout, s};
`else
      return {1'b0, cout, s};
`endif
   endfunction

   // Behavioural A+B+Cin / A-B reference for the random phase.
   function automatic logic [33:0] ref_add(input logic [31:0] ra, input logic [31:0] rb,
                                           input logic rc, input logic rs);
      logic [31:0] bb;
      logic [32:0] sum;
      bb  = rs ? ~rb : rb;
      sum = {1'b0, ra} + {1'b0, bb} + {32'd0, (rs | rc)};
      return pk(sum[31:0], sum[32], (ra[31] == bb[31]) && (sum[31] != ra[31]));
   endfunction

   // Output monitor: scoreboard order, and stability while stalled.
   logic [33:0] prev_obs;
   logic        prev_stall = 1'b0;
   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) chk("hold_stable", obs(), prev_obs);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
            else                   chk("result", obs(), exp_q.pop_front());
         end
         prev_stall = out_valid && !out_ready;
         prev_obs   = obs();
      end
   end

   task automatic drive(input logic [31:0] ta, input logic [31:0] tb2, input logic tc,
                        input logic ts, input logic [33:0] e);
      int cnt;
      @(negedge clk);
      a = ta; b = tb2; cin = tc; sub = ts; in_valid = 1'b1;
      #1;
      cnt = 0;
      while (!in_ready && cnt < 50) begin
         @(negedge clk);
         #1;
         cnt++;
      end
      stall_cnt += cnt;
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      else           exp_q.push_back(e);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   logic rdone;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1; rdone = 1'b0;

      // reset state
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_S", s, 0);
      chk("rst_Cout", cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);

      // latency: FF+1
      drive(32'h0000_00FF, 32'h1, 1'b0, 1'b0, pk(32'h0000_0100, 1'b0, 1'b0));
      @(negedge clk); in_valid = 1'b0; #1;
      chk("lat_cycle1", out_valid, 0);
      @(negedge clk); #1;
      chk("lat_cycle2", out_valid, 1);
      idle(2);

      // back-to-back directed stream
      stall_cnt = 0;
      drive(32'hFFFF_FFFF, 32'h0,         1'b1, 1'b0, pk(32'h0000_0000, 1'b1, 1'b0));
      drive(32'h0000_0005, 32'h7,         1'b0, 1'b1, pk(32'hFFFF_FFFE, 1'b0, 1'b0));
      drive(32'h8000_0000, 32'h1,         1'b0, 1'b1, pk(32'h7FFF_FFFF, 1'b1, 1'b1));
      drive(32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, pk(32'h8000_0000, 1'b0, 1'b1));
      drive(32'd10,        32'd3,         1'b1, 1'b1, pk(32'h0000_0007, 1'b1, 1'b0));
      drive(32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, pk(32'h9999_999A, 1'b0, 1'b0));
      drive(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, pk(32'h0001_FFFE, 1'b0, 1'b0));
      drive(32'h0,         32'h0,         1'b0, 1'b1, pk(32'h0000_0000, 1'b1, 1'b0));
      chk("throughput_stalls", stall_cnt, 0);
      idle(4);

      // backpressure: 4 transactions with the consumer stalled
      @(negedge clk);
      out_ready = 1'b0;
      fork
         begin
            drive(32'd1,         32'd2,         1'b0, 1'b0, pk(32'd3,          1'b0, 1'b0));
            drive(32'd10,        32'd20,        1'b0, 1'b0, pk(32'd30,         1'b0, 1'b0));
            drive(32'h100,       32'h1,         1'b0, 1'b1, pk(32'hFF,         1'b1, 1'b0));
            drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, pk(32'hFFFF_FFFE, 1'b1, 1'b0));
         end
         begin
            repeat (3) @(negedge clk);
            #2;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_S_first", s, 3);
            repeat (2) @(negedge clk);
            #2;
            chk("bp_S_held", s, 3);
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      idle(6);
      chk("bp_drained", exp_q.size(), 0);

      // reset with two transactions in flight
      drive(32'hAAAA_0000, 32'h1111, 1'b0, 1'b0, pk(32'hAAAA_1111, 1'b0, 1'b0));
      drive(32'h5555_0000, 32'h2222, 1'b0, 1'b0, pk(32'h5555_2222, 1'b0, 1'b0));
      #2;
      rst_n = 1'b0; in_valid = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_S", s, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1);
      idle(5);
      chk("post_rst_no_out", out_valid, 0);

      // random stream with random consumer backpressure
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic [31:0] ra, rb;
               logic        rc, rs;
               ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
               if (i % 37 == 0) ra = 32'hFFFF_FFFF;
               drive(ra, rb, rc, rs, ref_add(ra, rb, rc, rs));
               if ($urandom_range(0, 3) == 0) idle(1);
            end
            rdone = 1'b1;
         end
         begin
            while (!rdone) begin
               @(negedge clk);
               out_ready = 1'($urandom);
            end
         end
      join
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b0;
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
      #2;
      chk("random_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule
